// File: rtl/stepdown_pwm_ctrl.sv
// On-time sequencer for the stepdown loop: oscillator cycle start and current-limit trip in,
// non-overlapping high-side / low-side gate enables out, with dead time, blanking and max on-time.
//
// state | meaning
// IDLE  | converter disabled, both enables low
// LS_ON | low side conducting, waiting for cyc_start
// DT_HS | dead time before high-side turn-on
// HS_ON | high side conducting (blanking, current limit, max on-time)
// DT_LS | dead time before low-side turn-on
module stepdown_pwm_ctrl #(
  parameter int CW        = 8,
  parameter int DT_CYC    = 2,
  parameter int BLANK_CYC = 4,
  parameter int MAXON_CYC = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB,
  input  logic en,
  input  logic cyc_start,
  input  logic ilim_trip,
  output logic hs_on,
  output logic ls_on,
  output logic ilim_evt,
  output logic maxon_evt,
  output logic cyc_skip
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LS_ON = 3'd1;
  localparam logic [2:0] DT_HS = 3'd2;
  localparam logic [2:0] HS_ON = 3'd3;
  localparam logic [2:0] DT_LS = 3'd4;

  localparam logic [CW-1:0] L_DT_TC    = CW'(DT_CYC - 1);
  localparam logic [CW-1:0] L_MAXON_TC = CW'(MAXON_CYC - 1);
  localparam logic [CW-1:0] L_BLANK    = CW'(BLANK_CYC);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ilim_meta;
  logic          r_ilim_s;
  logic          r_hs_on;
  logic          r_ls_on;
  logic          r_ilim_evt;
  logic          r_maxon_evt;
  logic          r_cyc_skip;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_hs_nxt;
  logic          w_ls_nxt;
  logic          w_ilim_evt_nxt;
  logic          w_maxon_evt_nxt;
  logic          w_skip_nxt;
  logic          w_blank_done;
  logic          w_unused_pins;

  // Supply/ground/substrate pins exist only so the brick matches its neighbours.
  assign w_unused_pins = CELV ^ CELG ^ SUB;

  assign w_cnt_inc    = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
  assign w_blank_done = (r_cnt >= L_BLANK);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ilim_meta <= 1'b0;
      r_ilim_s    <= 1'b0;
    end else begin
      r_ilim_meta <= ilim_trip;
      r_ilim_s    <= r_ilim_meta;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = '0;
    w_hs_nxt        = 1'b0;
    w_ls_nxt        = 1'b0;
    w_ilim_evt_nxt  = 1'b0;
    w_maxon_evt_nxt = 1'b0;
    w_skip_nxt      = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = LS_ON;
          w_ls_nxt    = 1'b1;
          w_skip_nxt  = cyc_start;
        end
        LS_ON: begin
          if (cyc_start) begin
            w_state_nxt = DT_HS;
          end else begin
            w_ls_nxt = 1'b1;
          end
        end
        DT_HS: begin
          w_skip_nxt = cyc_start;
          if (r_cnt == L_DT_TC) begin
            w_state_nxt = HS_ON;
            w_hs_nxt    = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        HS_ON: begin
          w_skip_nxt = cyc_start;
          // Current limit outranks max on-time when both land on the same edge.
          if (w_blank_done && r_ilim_s) begin
            w_state_nxt    = DT_LS;
            w_ilim_evt_nxt = 1'b1;
          end else if (r_cnt == L_MAXON_TC) begin
            w_state_nxt     = DT_LS;
            w_maxon_evt_nxt = 1'b1;
          end else begin
            w_hs_nxt  = 1'b1;
            w_cnt_nxt = w_cnt_inc;
          end
        end
        DT_LS: begin
          w_skip_nxt = cyc_start;
          if (r_cnt == L_DT_TC) begin
            w_state_nxt = LS_ON;
            w_ls_nxt    = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hs_on     <= 1'b0;
      r_ls_on     <= 1'b0;
      r_ilim_evt  <= 1'b0;
      r_maxon_evt <= 1'b0;
      r_cyc_skip  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hs_on     <= w_hs_nxt;
      r_ls_on     <= w_ls_nxt;
      r_ilim_evt  <= w_ilim_evt_nxt;
      r_maxon_evt <= w_maxon_evt_nxt;
      r_cyc_skip  <= w_skip_nxt;
    end
  end

  assign hs_on     = r_hs_on;
  assign ls_on     = r_ls_on;
  assign ilim_evt  = r_ilim_evt;
  assign maxon_evt = r_maxon_evt;
  assign cyc_skip  = r_cyc_skip;

endmodule

// File: tb/tb_stepdown_pwm_ctrl.sv
// Bench for stepdown_pwm_ctrl: phase/age reference model compared every cycle,
// plus hand-computed timing literals for the directed scenarios.
module tb_stepdown_pwm_ctrl;

  localparam int DT    = 2;
  localparam int BLANK = 4;
  localparam int MAXON = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic cyc_start = 1'b0;
  logic ilim_trip = 1'b0;
  logic hs_on, ls_on, ilim_evt, maxon_evt, cyc_skip;

  int n_checks = 0;
  int n_pass   = 0;

  stepdown_pwm_ctrl #(.CW(8), .DT_CYC(DT), .BLANK_CYC(BLANK), .MAXON_CYC(MAXON)) dut (
    .CLK(clk), .RST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .cyc_start(cyc_start), .ilim_trip(ilim_trip),
    .hs_on(hs_on), .ls_on(ls_on), .ilim_evt(ilim_evt),
    .maxon_evt(maxon_evt), .cyc_skip(cyc_skip)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus age (cycles spent in the phase, 1 right after entry).
  localparam int P_OFF = 0, P_LS = 1, P_DTH = 2, P_HS = 3, P_DTL = 4;
  int   m_phase = P_OFF;
  int   m_age   = 0;
  bit   m_trip_d1 = 0, m_trip_d2 = 0;
  bit   m_hs = 0, m_ls = 0, m_ilim = 0, m_max = 0, m_skip = 0;

  always @(posedge clk or posedge rst) begin
    bit trip_seen;
    if (rst) begin
      m_phase = P_OFF; m_age = 0; m_trip_d1 = 0; m_trip_d2 = 0;
      m_ilim = 0; m_max = 0; m_skip = 0;
    end else begin
      trip_seen = m_trip_d2;
      m_trip_d2 = m_trip_d1;
      m_trip_d1 = ilim_trip;
      m_ilim = 0; m_max = 0; m_skip = 0;
      if (!en) begin
        m_phase = P_OFF; m_age = 0;
      end else if (m_phase == P_LS) begin
        if (cyc_start) begin m_phase = P_DTH; m_age = 1; end
      end else begin
        m_skip = cyc_start;
        case (m_phase)
          P_OFF: begin m_phase = P_LS; m_age = 0; end
          P_DTH: if (m_age == DT) begin m_phase = P_HS; m_age = 1; end else m_age++;
          P_HS: begin
            if (m_age > BLANK && trip_seen) begin m_phase = P_DTL; m_age = 1; m_ilim = 1; end
            else if (m_age == MAXON) begin m_phase = P_DTL; m_age = 1; m_max = 1; end
            else m_age++;
          end
          P_DTL: if (m_age == DT) begin m_phase = P_LS; m_age = 0; end else m_age++;
          default: m_phase = P_OFF;
        endcase
      end
    end
    m_hs = (m_phase == P_HS);
    m_ls = (m_phase == P_LS);
  end

  always @(negedge clk) begin
    n_checks++;
    if ({hs_on, ls_on, ilim_evt, maxon_evt, cyc_skip} !== {m_hs, m_ls, m_ilim, m_max, m_skip})
      $display("FAIL model_cmp t=%0t got hs/ls/ilim/max/skip=%b%b%b%b%b want %b%b%b%b%b", $time,
               hs_on, ls_on, ilim_evt, maxon_evt, cyc_skip, m_hs, m_ls, m_ilim, m_max, m_skip);
    else n_pass++;
    n_checks++;
    if ((hs_on & ls_on) !== 1'b0) $display("FAIL overlap t=%0t got hs=%b ls=%b want not both 1", $time, hs_on, ls_on);
    else n_pass++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s got %0d want %0d", name, act, exp);
    else n_pass++;
  endtask

  int o_hs_n, o_hs_first, o_ilim_n, o_max_n, o_skip_n, o_ls_fall, o_ls_back;

  // Starts a cycle at the next edge (edge 1) and watches n edges.
  task automatic run_cycle(input int n, input int trip_at_hs, input int skip_at_hs, input bit skip_in_dtl);
    o_hs_n = 0; o_hs_first = 0; o_ilim_n = 0; o_max_n = 0; o_skip_n = 0; o_ls_fall = 0; o_ls_back = 0;
    cyc_start = 1'b1;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      cyc_start = 1'b0;
      if (hs_on) begin o_hs_n++; if (o_hs_first == 0) o_hs_first = e; end
      if (ilim_evt) o_ilim_n++;
      if (maxon_evt) o_max_n++;
      if (cyc_skip) o_skip_n++;
      if (!ls_on && o_ls_fall == 0) o_ls_fall = e;
      if (ls_on && o_hs_n > 0 && o_ls_back == 0) o_ls_back = e;
      if (trip_at_hs > 0 && hs_on && o_hs_n == trip_at_hs) ilim_trip = 1'b1;
      if (skip_at_hs > 0 && hs_on && o_hs_n == skip_at_hs) cyc_start = 1'b1;
      if (skip_in_dtl && maxon_evt) cyc_start = 1'b1;
    end
    ilim_trip = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {hs_on, ls_on, ilim_evt, maxon_evt, cyc_skip}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_en0_ls", ls_on, 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_ls_1edge", ls_on, 1);
    @(negedge clk);

    // Normal cycle ended by max on-time.
    run_cycle(30, 0, 0, 0);
    chk("norm_ls_fall", o_ls_fall, 1);
    chk("norm_hs_first", o_hs_first, 3);
    chk("norm_hs_len", o_hs_n, 20);
    chk("norm_maxon_n", o_max_n, 1);
    chk("norm_ilim_n", o_ilim_n, 0);
    chk("norm_ls_back", o_ls_back, 25);

    // Trip held from HS turn-on: blanked through cnt=3.
    run_cycle(20, 1, 0, 0);
    chk("blank_hs_len", o_hs_n, 5);
    chk("blank_ilim_n", o_ilim_n, 1);
    chk("blank_maxon_n", o_max_n, 0);
    chk("blank_ls_back", o_ls_back, 10);

    // Late trip at HS cycle 10: three edges of latency to turn-off.
    run_cycle(25, 10, 0, 0);
    chk("late_hs_len", o_hs_n, 12);
    chk("late_ilim_n", o_ilim_n, 1);
    chk("late_ls_back", o_ls_back, 17);

    // Skips during HS_ON and DT_LS leave timing alone.
    run_cycle(30, 0, 5, 1);
    chk("skip_n", o_skip_n, 2);
    chk("skip_hs_len", o_hs_n, 20);
    chk("skip_ls_back", o_ls_back, 25);

    // Enable drop during DT_HS.
    cyc_start = 1'b1;
    @(negedge clk);
    cyc_start = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("endrop_both_off", {hs_on, ls_on}, 0);
    @(negedge clk);
    chk("endrop_stay_off", {hs_on, ls_on}, 0);
    en = 1'b1;
    @(negedge clk);
    chk("endrop_ls_back", ls_on, 1);

    // Async reset mid-HS_ON.
    cyc_start = 1'b1;
    @(negedge clk);
    cyc_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_hs", hs_on, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_off", {hs_on, ls_on}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_ls", ls_on, 1);

    // Random sweep; model compare and overlap check run every cycle.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      en        = ($urandom_range(0, 49) != 0);
      cyc_start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) ilim_trip = ~ilim_trip;
    end
    en = 1'b0; cyc_start = 1'b0; ilim_trip = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stepdown_pwm_ctrl.md
Name: stepdown_pwm_ctrl

Overview:
- Digital on-time sequencer for the stepdown loop control.
- Turns the oscillator's cycle-start pulse and the current-limit comparator trip into non-overlapping high-side and low-side gate enables, with dead time, leading-edge blanking and a maximum on-time.
- hs_on/ls_on feed the control NAND2 brick that gates the driver stage.
- Lives in the CONTROL hierarchy beside the generated logic bricks.

Parameters:
- CW, 8: width of the internal cycle counter.
- DT_CYC, 2: dead-time length in CLK cycles (1..2^CW-1).
- BLANK_CYC, 4: leading-edge blanking in CLK cycles after HS turn-on (0..MAXON_CYC-1).
- MAXON_CYC, 20: maximum HS on-time in CLK cycles (2..2^CW-1).

Ports:
- CLK  input  1  control clock; rising edge active.
- RST  input  1  asynchronous active-high reset.
- CELV  input  1  supply pin; carried for brick consistency, no logic function.
- CELG  input  1  ground pin; carried for brick consistency, no logic function.
- SUB  input  1  substrate pin; carried for brick consistency, no logic function.
- en  input  1  converter enable, synchronous to CLK.
- cyc_start  input  1  one-CLK pulse from the oscillator; starts a switching cycle.
- ilim_trip  input  1  current-comparator output; asynchronous, level.
- hs_on  output  1  high-side enable, registered.
- ls_on  output  1  low-side enable, registered.
- ilim_evt  output  1  one-cycle pulse: on-time ended by current limit.
- maxon_evt  output  1  one-cycle pulse: on-time ended by MAXON_CYC.
- cyc_skip  output  1  one-cycle pulse: cyc_start arrived outside LS_ON and was dropped.

Behaviour:
- Reset: RST=1 asynchronously forces:
  - state IDLE, cnt=0;
  - hs_on=0, ls_on=0, ilim_evt=0, maxon_evt=0, cyc_skip=0;
  - both ilim synchronizer flops to 0.
  - Reset mid-cycle drops both enables immediately, with no dead-time sequence.
- ilim_trip passes through a 2-flop synchronizer; ilim_s is the second-flop output. Trip-to-ilim_s latency is 2 CLK edges.
- All outputs are registered. The state/cnt update at an edge is visible on the outputs after that same edge.
- IDLE: hs_on=0, ls_on=0. If en=1 at an edge → LS_ON.
- LS_ON: ls_on=1. If cyc_start=1 → DT_HS, cnt=0, ls_on=0.
- DT_HS: both enables 0; cnt increments each edge. When cnt==DT_CYC-1 → HS_ON, cnt=0, hs_on=1. Both-off time is exactly DT_CYC cycles.
- HS_ON: hs_on=1; cnt increments each edge. Priority, evaluated each edge:
  - (a) cnt>=BLANK_CYC and ilim_s=1 → DT_LS, ilim_evt=1;
  - (b) else cnt==MAXON_CYC-1 → DT_LS, maxon_evt=1.
  - If both hold at the same edge, ilim takes priority and maxon_evt stays 0.
  - ilim_s is ignored while cnt<BLANK_CYC.
  - Maximum HS high time is MAXON_CYC cycles.
- DT_LS: both enables 0. After DT_CYC cycles → LS_ON, ls_on=1.
- en=0 in any state: next edge → IDLE, both enables 0, no dead time. Event pulses are not generated by this exit.
- cyc_start while in DT_HS, HS_ON, DT_LS or IDLE: ignored, and cyc_skip=1 for one cycle. IDLE is excluded from this rule when en=0.
- cyc_start coincident with the HS_ON exit edge: ignored, and cyc_skip=1.
- Invariant: hs_on and ls_on are never both 1 on any cycle, including across reset and en transitions.
- cnt saturates; it never wraps. Terminal compares are ==, and the parameter ranges guarantee no overflow.

Test Plan:
- Reset/idle: assert RST mid-HS_ON (hs_on=1) → hs_on=0, ls_on=0 without waiting for CLK. Release RST, en=1 → ls_on=1 after 1 edge.
- Normal cycle, DT_CYC=2, MAXON_CYC=20, ilim_trip=0: cyc_start pulse →
  - ls_on falls at edge 1;
  - hs_on high at edges 3..22 (20 cycles), with maxon_evt=1 at the exit;
  - both off for 2 cycles, then ls_on=1.
- Current limit with blanking, BLANK_CYC=4: hold ilim_trip=1 from HS turn-on → ignored through cnt=3, so hs_on stays high exactly 5 cycles. Then ilim_evt=1 for one cycle, and maxon_evt=0.
- Late trip: raise ilim_trip at HS cycle 10 → hs_on falls 2–3 edges later (synchronizer latency), with ilim_evt=1.
- Skip: pulse cyc_start during HS_ON and again during DT_LS → two single-cycle cyc_skip pulses; the current cycle's timing is unchanged.
- Enable drop: en=0 during DT_HS → IDLE at the next edge, both enables 0. A random sweep (10k cycles, random en/cyc_start/ilim) checks the invariant that hs_on&ls_on never equals 1.
